// File: rtl/sprite_layer_mapper.sv
// Two-stage pixel compositor: one animated, flippable sprite over a stretched background.
// Drives external synchronous sprite/background ROM addresses and muxes their palette colours.
module sprite_layer_mapper #(
    parameter int SPR_W        = 30,
    parameter int SPR_H        = 64,
    parameter int NUM_FRAMES   = 4,
    parameter int FRAME_HOLD   = 6,
    parameter int IDX_W        = 3,
    parameter int TRANSP_INDEX = 0,
    parameter int BG_W         = 320,
    parameter int BG_SHIFT     = 1,
    parameter int SPR_AW       = 13,
    parameter int BG_AW        = 17,
    localparam int FW          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int HW          = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_tick,
    input  logic [9:0]        SprX,
    input  logic [9:0]        SprY,
    input  logic              flip,
    input  logic              anim_en,
    input  logic              anim_restart,
    output logic [SPR_AW-1:0] spr_rom_addr,
    input  logic [IDX_W-1:0]  spr_rom_q,
    input  logic [3:0]        spr_red,
    input  logic [3:0]        spr_green,
    input  logic [3:0]        spr_blue,
    output logic [BG_AW-1:0]  bg_rom_addr,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic [FW-1:0]     frame_idx
);

    logic [9:0]    spr_x_l, spr_y_l;
    logic          flip_l;
    logic [HW-1:0] hold_cnt;

    // Geometry in 11-bit two's complement; bit 10 set means "left of / above the sprite".
    logic [10:0]       x0, y0, lx, ly, sx;
    logic              hit;
    logic [31:0]       frame_base, spr_addr_full, bg_addr_full;

    logic hit_a, blank_a, hit_b, blank_b;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        x0            = {1'b0, spr_x_l} - 11'(SPR_W / 2);
        y0            = {1'b0, spr_y_l} - 11'(SPR_H / 2);
        lx            = {1'b0, DrawX} - x0;
        ly            = {1'b0, DrawY} - y0;
        hit           = !lx[10] && (lx < 11'(SPR_W)) && !ly[10] && (ly < 11'(SPR_H));
        sx            = flip_l ? (11'(SPR_W - 1) - lx) : lx;
        frame_base    = 32'(frame_idx) * 32'(SPR_W * SPR_H);
        spr_addr_full = frame_base;
        if (hit)
            spr_addr_full = frame_base + 32'(ly) * 32'(SPR_W) + 32'(sx);
        bg_addr_full  = 32'(DrawX >> BG_SHIFT) + 32'(DrawY >> BG_SHIFT) * 32'(BG_W);
    end

    // Position and flip only change at the start of vblank, so a frame never tears.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            spr_x_l <= '0;
            spr_y_l <= '0;
            flip_l  <= 1'b0;
        end else if (frame_tick) begin
            spr_x_l <= SprX;
            spr_y_l <= SprY;
            flip_l  <= flip;
        end
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            frame_idx <= '0;
            hold_cnt  <= '0;
        end else if (anim_restart) begin
            frame_idx <= '0;
            hold_cnt  <= '0;
        end else if (frame_tick && anim_en) begin
            if (hold_cnt == HW'(FRAME_HOLD - 1)) begin
                hold_cnt  <= '0;
                frame_idx <= (frame_idx == FW'(NUM_FRAMES - 1)) ? '0 : frame_idx + 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // Stage A: addresses out to the ROMs; stage B: wait for ROM data; then register colour.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            spr_rom_addr <= '0;
            bg_rom_addr  <= '0;
            hit_a        <= 1'b0;
            blank_a      <= 1'b0;
            hit_b        <= 1'b0;
            blank_b      <= 1'b0;
            Red          <= '0;
            Green        <= '0;
            Blue         <= '0;
        end else begin
            spr_rom_addr <= SPR_AW'(spr_addr_full);
            bg_rom_addr  <= BG_AW'(bg_addr_full);
            hit_a        <= hit;
            blank_a      <= blank;
            hit_b        <= hit_a;
            blank_b      <= blank_a;
            if (!blank_b) begin
                Red   <= '0;
                Green <= '0;
                Blue  <= '0;
            end else if (hit_b && (spr_rom_q != IDX_W'(TRANSP_INDEX))) begin
                Red   <= {spr_red, 4'h0};
                Green <= {spr_green, 4'h0};
                Blue  <= {spr_blue, 4'h0};
            end else begin
                Red   <= {bg_red, 4'h0};
                Green <= {bg_green, 4'h0};
                Blue  <= {bg_blue, 4'h0};
            end
        end
    end

endmodule

// File: tb/tb_sprite_layer_mapper.sv
// Directed bench for sprite_layer_mapper with default parameters and simple ROM/palette stand-ins.
// Sprite palette: red={1,q}, green=3, blue=5. Background palette: red=q[3:0], green=q[7:4], blue=C.
module tb_sprite_layer_mapper;

    logic        vga_clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY, SprX, SprY;
    logic        blank, frame_tick, flip, anim_en, anim_restart;
    logic [12:0] spr_rom_addr;
    logic [2:0]  spr_rom_q;
    logic [3:0]  spr_red, spr_green, spr_blue;
    logic [16:0] bg_rom_addr;
    logic [3:0]  bg_red, bg_green, bg_blue;
    logic [7:0]  Red, Green, Blue;
    logic [1:0]  frame_idx;

    logic [2:0]  spr_data;
    logic [16:0] bg_q;

    int errors = 0;
    int checks = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_layer_mapper dut (
        .vga_clk      (vga_clk),
        .Reset        (Reset),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .blank        (blank),
        .frame_tick   (frame_tick),
        .SprX         (SprX),
        .SprY         (SprY),
        .flip         (flip),
        .anim_en      (anim_en),
        .anim_restart (anim_restart),
        .spr_rom_addr (spr_rom_addr),
        .spr_rom_q    (spr_rom_q),
        .spr_red      (spr_red),
        .spr_green    (spr_green),
        .spr_blue     (spr_blue),
        .bg_rom_addr  (bg_rom_addr),
        .bg_red       (bg_red),
        .bg_green     (bg_green),
        .bg_blue      (bg_blue),
        .Red          (Red),
        .Green        (Green),
        .Blue         (Blue),
        .frame_idx    (frame_idx)
    );

    // Synchronous ROM stand-ins with one cycle of latency.
    always_ff @(posedge vga_clk) begin
        spr_rom_q <= spr_data;
        bg_q      <= bg_rom_addr;
    end

    assign spr_red   = {1'b1, spr_rom_q};
    assign spr_green = 4'h3;
    assign spr_blue  = 4'h5;
    assign bg_red    = bg_q[3:0];
    assign bg_green  = bg_q[7:4];
    assign bg_blue   = 4'hC;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input logic restart);
        @(negedge vga_clk);
        frame_tick   = 1'b1;
        anim_restart = restart;
        @(posedge vga_clk);
        #1;
        frame_tick   = 1'b0;
        anim_restart = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    // Present one pixel: check the address after edge t and the colour after edge t+2.
    task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic b, input logic [2:0] sd,
                         input logic [31:0] exp_addr, input logic [31:0] exp_rgb);
        @(negedge vga_clk);
        DrawX    = x;
        DrawY    = y;
        blank    = b;
        spr_data = sd;
        @(posedge vga_clk);
        #1;
        check({tag, "_addr"}, 32'(spr_rom_addr), exp_addr);
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        check({tag, "_rgb"}, 32'({Red, Green, Blue}), exp_rgb);
    endtask

    initial begin
        Reset = 1'b1;
        DrawX = '0; DrawY = '0; blank = 1'b0;
        SprX = '0; SprY = '0; flip = 1'b0;
        frame_tick = 1'b0; anim_en = 1'b0; anim_restart = 1'b0;
        spr_data = '0;

        repeat (2) @(posedge vga_clk);
        #1;
        check("reset_rgb",   32'({Red, Green, Blue}), 32'h0);
        check("reset_frame", 32'(frame_idx), 32'd0);
        check("reset_saddr", 32'(spr_rom_addr), 32'd0);
        check("reset_baddr", 32'(bg_rom_addr), 32'd0);
        @(negedge vga_clk);
        Reset = 1'b0;

        // Sprite centred at (100,100): top-left corner (85,68).
        SprX = 10'd100; SprY = 10'd100; flip = 1'b0;
        tick(1'b0);
        pixel("corner",  10'd85,  10'd68,  1'b1, 3'd3, 32'd0,    32'hB03050);
        pixel("far",     10'd114, 10'd131, 1'b1, 3'd3, 32'd1919, 32'hB03050);
        pixel("left_ms", 10'd84,  10'd68,  1'b1, 3'd3, 32'd0,    32'hA0A0C0);
        check("left_ms_bgaddr", 32'(bg_rom_addr), 32'd10922);

        // Transparency and blanking on a hit pixel.
        pixel("transp", 10'd85, 10'd68, 1'b1, 3'd0, 32'd0, 32'hA0A0C0);
        pixel("opaque", 10'd85, 10'd68, 1'b1, 3'd5, 32'd0, 32'hD03050);
        pixel("blank",  10'd85, 10'd68, 1'b0, 3'd5, 32'd0, 32'h000000);

        // Flip latched: first column maps to sx=29.
        flip = 1'b1;
        tick(1'b0);
        pixel("flip", 10'd85, 10'd68, 1'b1, 3'd3, 32'd29, 32'hB03050);

        // Animation with FRAME_HOLD=6.
        flip = 1'b0;
        anim_en = 1'b1;
        ticks(5);
        check("anim_t5",  32'(frame_idx), 32'd0);
        ticks(1);
        check("anim_t6",  32'(frame_idx), 32'd1);
        ticks(6);
        check("anim_t12", 32'(frame_idx), 32'd2);
        anim_en = 1'b0;
        pixel("frame2", 10'd85, 10'd68, 1'b1, 3'd3, 32'd3840, 32'hB03050);
        anim_en = 1'b1;
        ticks(6);
        check("anim_t18", 32'(frame_idx), 32'd3);
        ticks(6);
        check("anim_t24", 32'(frame_idx), 32'd0);

        // Restart on tick 9 of a fresh run.
        ticks(8);
        check("rst_t8",  32'(frame_idx), 32'd1);
        tick(1'b1);
        check("rst_t9",  32'(frame_idx), 32'd0);
        ticks(5);
        check("rst_t14", 32'(frame_idx), 32'd0);
        ticks(1);
        check("rst_t15", 32'(frame_idx), 32'd1);

        // anim_en low freezes the frame.
        anim_en = 1'b0;
        ticks(7);
        check("freeze", 32'(frame_idx), 32'd1);

        // Mid-line reset: colour clears without a clock edge.
        pixel("pre_rst", 10'd84, 10'd68, 1'b1, 3'd3, 32'd1920, 32'hA0A0C0);
        @(negedge vga_clk);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rgb",   32'({Red, Green, Blue}), 32'h0);
        check("async_frame", 32'(frame_idx), 32'd0);
        @(negedge vga_clk);
        Reset = 1'b0;
        // Latched position is now 0, so (0,0) is lx=15, ly=32 inside the sprite.
        pixel("post_rst", 10'd0, 10'd0, 1'b1, 3'd0, 32'd975, 32'h0000C0);

        // Clipping at the top-left screen edge: X0=-10, Y0=-22.
        SprX = 10'd5; SprY = 10'd10;
        tick(1'b0);
        pixel("clip_hit",  10'd0,  10'd0, 1'b1, 3'd3, 32'd670, 32'hB03050);
        pixel("clip_miss", 10'd20, 10'd0, 1'b1, 3'd3, 32'd0,   32'hA000C0);
        SprX = 10'd100;
        pixel("no_tear",   10'd0,  10'd0, 1'b1, 3'd3, 32'd670, 32'hB03050);
        tick(1'b0);
        pixel("relatched", 10'd0,  10'd0, 1'b1, 3'd3, 32'd0,   32'h0000C0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_layer_mapper.md
Name: sprite_layer_mapper

Overview:
- Parametrised, pipelined pixel compositor. Draws one animated, flippable sprite over a stretched background.
- Sits between the VGA controller's DrawX/DrawY/blank outputs and the video DAC.
- Drives address ports of external synchronous ROMs and reads back their palette RGB.
- Adds multi-frame animation, horizontal flip, index-keyed transparency, vblank-latched position and off-screen clipping.

Parameters:
- SPR_W, 30, sprite width in pixels
- SPR_H, 64, sprite height in pixels
- NUM_FRAMES, 4, animation frames stored back-to-back in the sprite ROM
- FRAME_HOLD, 6, frame_tick pulses per animation frame (>=1)
- IDX_W, 3, sprite palette index width
- TRANSP_INDEX, 0, sprite palette index treated as transparent
- BG_W, 320, background ROM row width
- BG_SHIFT, 1, background stretch: DrawX and DrawY are right-shifted by this amount
- SPR_AW, 13, sprite ROM address width (>= clog2(NUM_FRAMES*SPR_W*SPR_H))
- BG_AW, 17, background ROM address width

Ports:
- vga_clk  in  1  pixel clock
- Reset  in  1  asynchronous, active-high reset
- DrawX, DrawY  in  10  current pixel coordinate
- blank  in  1  1 = active video
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- SprX, SprY  in  10  requested sprite centre
- flip  in  1  1 = mirror horizontally
- anim_en  in  1  advance animation
- anim_restart  in  1  force frame 0
- spr_rom_addr  out  SPR_AW  sprite ROM address
- spr_rom_q  in  IDX_W  sprite ROM data, 1-cycle latency
- spr_red, spr_green, spr_blue  in  4  sprite palette output, combinational from spr_rom_q
- bg_rom_addr  out  BG_AW  background ROM address
- bg_red, bg_green, bg_blue  in  4  background palette output
- Red, Green, Blue  out  8  registered pixel colour
- frame_idx  out  clog2(NUM_FRAMES)  current animation frame

Behaviour:
- Reset (async):
  - Zeroes all pipeline registers, Red/Green/Blue, frame_idx, hold counter, spr_rom_addr, bg_rom_addr.
  - Zeroes latched position and latched flip.
- Latching on frame_tick:
  - SprX, SprY and flip are captured into internal registers only on frame_tick.
  - All hit and address math uses the latched values, so there is no mid-frame tearing.
- Geometry:
  - Signed 11-bit arithmetic.
  - X0 = SprX_l - SPR_W/2; Y0 = SprY_l - SPR_H/2.
  - lx = DrawX - X0; ly = DrawY - Y0.
  - hit = (0 <= lx < SPR_W) && (0 <= ly < SPR_H).
  - A negative X0/Y0 clips correctly; there is no wrap onto the opposite screen edge.
- Addressing:
  - sx = latched flip ? SPR_W-1-lx : lx.
  - spr_rom_addr = frame_idx*SPR_W*SPR_H + ly*SPR_W + sx.
  - When hit = 0, spr_rom_addr holds the frame base address.
  - bg_rom_addr = (DrawX>>BG_SHIFT) + (DrawY>>BG_SHIFT)*BG_W.
- Pipeline (latency 2):
  - Edge t: register addresses, hit, blank (stage A).
  - Edge t+1: ROMs present q; register hit and blank again (stage B).
  - Edge t+2: register RGB.
- Output colour at edge t+2:
  - If stage-B blank = 0: RGB = 0.
  - Else if stage-B hit and spr_rom_q != TRANSP_INDEX: RGB = {spr_*,4'h0}.
  - Else: RGB = {bg_*,4'h0}.
- Animation counter (updates only on frame_tick):
  - anim_restart (any cycle) has priority: frame_idx = 0, hold counter = 0.
  - Else if frame_tick && anim_en: hold counter increments.
  - When the hold counter reaches FRAME_HOLD-1, it clears and frame_idx increments, wrapping from NUM_FRAMES-1 to 0.
  - anim_en = 0 freezes both frame_idx and the hold counter.
  - FRAME_HOLD = 1: frame_idx advances on every tick.
- Simultaneous events:
  - frame_tick on the same edge as a pixel: the new latched position and frame apply from the next pixel.
  - Reset mid-line: outputs go to 0 immediately; first valid RGB appears 2 edges after Reset deasserts.

Test Plan:
- Reset=1 mid-frame -> Red/Green/Blue = 0 and frame_idx = 0 asynchronously; after release and DrawX=0 at edge t, RGB = bg colour at edge t+2.
- SprX=100, SprY=100 latched, frame 0, flip=0 -> (DrawX 85, DrawY 68): spr_rom_addr = 0. (114, 131): addr = 1919. (84, 68): hit = 0, background shown.
- Same position, flip=1 latched -> (85, 68): addr = 29. frame_idx=2, (85, 68), flip=0: addr = 3840.
- spr_rom_q = TRANSP_INDEX on a hit pixel -> bg colour out. spr_rom_q = 5 -> {spr_red,0}. blank=0 at that pixel -> RGB = 0.
- FRAME_HOLD=6, anim_en=1 -> frame_idx = 1 after 6 ticks, 3 after 18, 0 after 24. anim_restart on tick 9 -> frame_idx = 0, next advance at tick 15.
- SprX=5, SprY=10 -> X0 = -10, Y0 = -22. (0, 0) hits with addr = 22*30 + 10 = 670. (20, 0) misses. SprX changed mid-frame without frame_tick -> no hit change until next tick.
